mem_init_sequencer: RTL and testbench

Parametrised memory initialiser for the RC4 datapath: on a start pulse it walks every address of a single-port RAM once and writes a mode-selected pattern. The patterns are identity (s[i] = i), constant fill, descending, or address XOR a constant. It generalises the fixed 256-entry S-array populate step: width, depth and pattern are configurable, start/done/abort are handshaked, and the write strobe protocol is explicit. It sits between the top-level RC4 controller and the S-memory (or any scratch RAM) write port, muxed with the swap and decrypt stages.

---
 rtl/mem_init_sequencer.sv | 115 +++++++++++
 tb/tb_mem_init_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_init_sequencer.sv
// mem_init_sequencer: walks RAM addresses 0..DEPTH-1 writing an identity, fill, descending or xor pattern.
// Define MEM_INIT_VERIFY_EN to add a read-back compare pass after the writes.
module mem_init_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_value,
    output logic [ADDR_W-1:0] address_out,
    output logic [DATA_W-1:0] data_out,
    output logic              write_enable_out,
    output logic              busy,
    output logic              done,
    input  logic [DATA_W-1:0] rdata_in,
    output logic              verify_error,
    output logic [ADDR_W-1:0] error_address
);
    localparam logic [2:0] IDLE = 3'd0, SETUP = 3'd1, WRITE = 3'd2, HOLD = 3'd3, DONE = 3'd4;
`ifdef MEM_INIT_VERIFY_EN
    localparam logic [2:0] VADDR = 3'd5, VWAIT = 3'd6, VCMP = 3'd7;
`endif
    localparam int PW = DATA_W > ADDR_W ? DATA_W : ADDR_W;
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

    logic [2:0]        state;
    logic [ADDR_W:0]   cnt;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] fill_q;
    logic [PW-1:0]     a_ext, f_ext, pat;
    logic              accept, wr_phase;

    assign accept = (state == IDLE || state == DONE) && start && !abort;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= '0;
            fill_q <= '0;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (accept) begin
                    state  <= SETUP;
                    cnt    <= '0;
                    mode_q <= mode;
                    fill_q <= fill_value;
                end
                SETUP: state <= WRITE;
                WRITE: state <= HOLD;
                HOLD: if (cnt == LAST) begin
`ifdef MEM_INIT_VERIFY_EN
                    state <= VADDR;
                    cnt   <= '0;
`else
                    state <= DONE;
`endif
                end else begin
                    state <= SETUP;
                    cnt   <= cnt + 1'b1;
                end
`ifdef MEM_INIT_VERIFY_EN
                VADDR: state <= VWAIT;
                VWAIT: state <= VCMP;
                VCMP: if (cnt == LAST) begin
                    state <= DONE;
                end else begin
                    state <= VADDR;
                    cnt   <= cnt + 1'b1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // Pattern is computed at the wider of address/data width, then truncated to the data bus.
    assign a_ext = PW'(cnt[ADDR_W-1:0]);
    assign f_ext = PW'(fill_q);
    assign pat   = mode_q == 2'd0 ? a_ext :
                   mode_q == 2'd1 ? f_ext :
                   mode_q == 2'd2 ? PW'(DEPTH - 1) - a_ext : a_ext ^ f_ext;

    assign wr_phase         = state == SETUP || state == WRITE || state == HOLD;
    assign address_out      = cnt[ADDR_W-1:0];
    assign data_out         = wr_phase ? DATA_W'(pat) : '0;
    assign write_enable_out = state == WRITE;
    assign busy             = state != IDLE && state != DONE;
    assign done             = state == DONE;

`ifdef MEM_INIT_VERIFY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            verify_error  <= 1'b0;
            error_address <= '0;
        end else if (accept) begin
            verify_error  <= 1'b0;
            error_address <= '0;
        end else if (state == VCMP && !verify_error && rdata_in != DATA_W'(pat)) begin
            verify_error  <= 1'b1;
            error_address <= cnt[ADDR_W-1:0];
        end
    end
`else
    logic unused_rdata;
    assign unused_rdata  = ^rdata_in;
    assign verify_error  = 1'b0;
    assign error_address = '0;
`endif
endmodule

// File: tb/tb_mem_init_sequencer.sv
// tb_mem_init_sequencer: drives a DEPTH=256 and a DEPTH=16 sequencer into RAM models and checks
// contents, strobe counts, latency and handshakes against a pattern model.
module tb_mem_init_sequencer;
    localparam int VX =
`ifdef MEM_INIT_VERIFY_EN
        2;
`else
        1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [1:0] start, abort, we, busy, done, verr, wipe;
    logic [1:0] mode [2];
    logic [7:0] fill [2];
    logic [7:0] addr [2];
    logic [7:0] dout [2];
    logic [7:0] rdata [2];
    logic [7:0] eaddr [2];
    logic [7:0] ram [2][256];
    int strobes [2] = '{0, 0};
    int bad_addr = -1;
    int n_chk = 0, n_fail = 0;

    mem_init_sequencer #(.ADDR_W(8), .DATA_W(8), .DEPTH(256)) u_big (
        .clk(clk), .reset_n(reset_n), .start(start[0]), .abort(abort[0]), .mode(mode[0]),
        .fill_value(fill[0]), .address_out(addr[0]), .data_out(dout[0]), .write_enable_out(we[0]),
        .busy(busy[0]), .done(done[0]), .rdata_in(rdata[0]), .verify_error(verr[0]),
        .error_address(eaddr[0]));

    mem_init_sequencer #(.ADDR_W(8), .DATA_W(8), .DEPTH(16)) u_small (
        .clk(clk), .reset_n(reset_n), .start(start[1]), .abort(abort[1]), .mode(mode[1]),
        .fill_value(fill[1]), .address_out(addr[1]), .data_out(dout[1]), .write_enable_out(we[1]),
        .busy(busy[1]), .done(done[1]), .rdata_in(rdata[1]), .verify_error(verr[1]),
        .error_address(eaddr[1]));

    // RAM models: registered read with one-cycle latency; unit 0 can corrupt one address on read.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (wipe[k]) begin
                for (int j = 0; j < 256; j++) ram[k][j] <= 8'hEE;
            end else if (we[k]) begin
                ram[k][addr[k]] <= dout[k];
                strobes[k] <= strobes[k] + 1;
            end
            rdata[k] <= ram[k][addr[k]] ^ ((k == 0 && int'(addr[k]) == bad_addr) ? 8'h40 : 8'h00);
        end
    end

    function automatic logic [7:0] ref_word(input logic [1:0] m, input int i, input int depth,
                                            input logic [7:0] f);
        case (m)
            2'd0:    return 8'(i);
            2'd1:    return f;
            2'd2:    return 8'(depth - 1 - i);
            default: return 8'(i) ^ f;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_words(input int k, input string tag, input logic [1:0] m,
                             input logic [7:0] f, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) if (ram[k][i] !== ref_word(m, i, k ? 16 : 256, f)) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic wipe_ram(input int k);
        @(negedge clk); wipe[k] = 1'b1;
        @(negedge clk); wipe[k] = 1'b0;
    endtask

    // poke 1: change mode/fill mid-pass; poke 2: also pulse start while busy.
    task automatic run_pass(input int k, input logic [1:0] m, input logic [7:0] f, input int poke);
        int depth = k ? 16 : 256;
        int lat, s0;
        logic busy_prev = 1'b0;
        s0 = strobes[k];
        @(negedge clk); mode[k] = m; fill[k] = f; start[k] = 1'b1;
        @(negedge clk); start[k] = 1'b0; lat = 1;
        chk("busy_after_start", busy[k], 1);
        chk("done_cleared", done[k], 0);
        while (done[k] !== 1'b1 && lat < 8 * depth) begin
            if (poke != 0 && lat == 7) begin
                mode[k] = ~m; fill[k] = ~f; start[k] = poke == 2;
            end
            if (lat == 8) start[k] = 1'b0;
            busy_prev = busy[k];
            @(negedge clk); lat++;
        end
        chk("busy_falls_with_done", {busy_prev, busy[k]}, 2'b10);
        chk("latency", lat, 3 * VX * depth + 1);
        chk("strobe_count", strobes[k] - s0, depth);
        chk("no_strobe_in_done", we[k], 0);
    endtask

    initial begin
        int s0, n;
        logic [1:0] m;
        logic [7:0] f;
        reset_n = 1'b0; start = '0; abort = '0; wipe = 2'b11;
        mode = '{2'd0, 2'd0}; fill = '{8'h00, 8'h00};
        repeat (2) @(negedge clk);
        wipe = 2'b00;
        for (int k = 0; k < 2; k++) begin
            chk("rst_addr", addr[k], 0);
            chk("rst_data", dout[k], 0);
            chk("rst_we", we[k], 0);
            chk("rst_busy", busy[k], 0);
            chk("rst_done", done[k], 0);
            chk("rst_verr", verr[k], 0);
            chk("rst_eaddr", eaddr[k], 0);
        end
        reset_n = 1'b1;

        run_pass(0, 2'd0, 8'h00, 0);
        chk_words(0, "identity_256", 2'd0, 8'h00, 256);
        chk("done_level", done[0], 1);
        chk("clean_verr", verr[0], 0);
        chk("clean_eaddr", eaddr[0], 0);

        wipe_ram(1);
        run_pass(1, 2'd1, 8'hA5, 0);
        chk_words(1, "fill_16", 2'd1, 8'hA5, 16);
        chk("fill_untouched_16", ram[1][16], 8'hEE);

        run_pass(1, 2'd2, 8'h00, 0);
        chk("desc_first", ram[1][0], 15);
        chk("desc_last", ram[1][15], 0);
        chk_words(1, "desc_16", 2'd2, 8'h00, 16);

        run_pass(1, 2'd3, 8'h0F, 1);
        chk_words(1, "xor_latched", 2'd3, 8'h0F, 16);

        for (int r = 0; r < 4; r++) begin
            m = 2'($urandom_range(3));
            f = 8'($urandom);
            run_pass(1, m, f, 1);
            chk_words(1, "random_pass", m, f, 16);
        end

        // Abort raised during the 10th WRITE cycle.
        wipe_ram(1);
        s0 = strobes[1]; n = 0;
        @(negedge clk); mode[1] = 2'd0; start[1] = 1'b1;
        @(negedge clk); start[1] = 1'b0;
        for (int c = 0; c < 100 && n < 10; c++) begin
            if (we[1]) n++;
            if (n < 10) @(negedge clk);
        end
        abort[1] = 1'b1;
        @(negedge clk); abort[1] = 1'b0;
        chk("abort_busy", busy[1], 0);
        chk("abort_done", done[1], 0);
        chk("abort_we", we[1], 0);
        repeat (10) @(negedge clk);
        chk("abort_strobes", strobes[1] - s0, 10);
        chk_words(1, "abort_words", 2'd0, 8'h00, 10);
        chk("abort_untouched", ram[1][10], 8'hEE);

        run_pass(1, 2'd1, 8'h3C, 2);
        chk_words(1, "start_while_busy", 2'd1, 8'h3C, 16);
        run_pass(1, 2'd2, 8'h00, 0);
        chk_words(1, "second_pass", 2'd2, 8'h00, 16);

        s0 = strobes[1];
        @(negedge clk); start[1] = 1'b1; abort[1] = 1'b1;
        @(negedge clk); start[1] = 1'b0; abort[1] = 1'b0;
        chk("start_abort_done", done[1], 0);
        chk("start_abort_busy", busy[1], 0);
        repeat (6) @(negedge clk);
        chk("start_abort_strobes", strobes[1] - s0, 0);

        // Asynchronous reset during a WRITE cycle.
        @(negedge clk); mode[0] = 2'd1; fill[0] = 8'h77; start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        for (int c = 0; c < 20 && we[0] !== 1'b1; c++) @(negedge clk);
        chk("we_before_reset", we[0], 1);
        #1 reset_n = 1'b0;
        #1;
        chk("reset_we_async", we[0], 0);
        chk("reset_busy_async", busy[0], 0);
        chk("reset_data_async", dout[0], 0);
        @(negedge clk); reset_n = 1'b1;

`ifdef MEM_INIT_VERIFY_EN
        bad_addr = 37;
        run_pass(0, 2'd0, 8'h00, 0);
        chk("verify_error_set", verr[0], 1);
        chk("verify_error_addr", eaddr[0], 37);
        bad_addr = -1;
        run_pass(0, 2'd3, 8'h5A, 0);
        chk("verify_clean", verr[0], 0);
        chk_words(0, "verify_words", 2'd3, 8'h5A, 256);
`else
        run_pass(0, 2'd3, 8'h5A, 0);
        chk_words(0, "xor_256", 2'd3, 8'h5A, 256);
        chk("tied_verr", verr[0], 0);
        chk("tied_eaddr", eaddr[0], 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
